// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: ALU pass-through, input-port copy, or
// LOAD/STORE against internal data memory with programmable wait states.
module mem_access_stage #(
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned MEM_LATENCY = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              valid_In,
   input  logic [19:0]       instruction_In,
   input  logic [DATA_W-1:0] aluResult_In,
   input  logic [DATA_W-1:0] storeData_In,
   input  logic [DATA_W-1:0] inputPort_In,
   input  logic              writeEnable_In,
   input  logic [1:0]        address_Control_In,
   input  logic              flush,
   output logic              busy_Out,
   output logic              valid_Out,
   output logic [19:0]       instruction_Out,
   output logic [DATA_W-1:0] result_Out
);

   localparam int unsigned DEPTH    = 2 ** ADDR_W;
   localparam int unsigned CNT_W    = 4;
   localparam int unsigned INSTR_W  = 20;
   localparam bit          HAS_WAIT = (MEM_LATENCY != 0);

   typedef enum logic {
      S_IDLE,
      S_WAIT
   } state_t;

   state_t               state, state_n;
   logic [CNT_W-1:0]     cnt, cnt_n;
   logic [INSTR_W-1:0]   lat_instr, lat_instr_n;
   logic [ADDR_W-1:0]    lat_addr, lat_addr_n;
   logic [DATA_W-1:0]    lat_data, lat_data_n;
   logic                 lat_we, lat_we_n;
   logic                 valid_n;
   logic [INSTR_W-1:0]   instr_n;
   logic [DATA_W-1:0]    result_n;

   logic [DATA_W-1:0]    mem [DEPTH];
   logic                 accept_c;
   logic                 is_mem_c;
   logic                 mem_we_c;
   logic [ADDR_W-1:0]    mem_addr_c;
   logic [DATA_W-1:0]    mem_wdata_c;
   logic [DATA_W-1:0]    mem_rdata_c;

   assign accept_c    = (state == S_IDLE) && valid_In && !flush;
   assign is_mem_c    = (address_Control_In == 2'b10);
   assign busy_Out    = ((state == S_IDLE) && valid_In && is_mem_c && HAS_WAIT) ||
                        (state == S_WAIT);

   // Memory port: live inputs while idle, latched operands while waiting.
   assign mem_addr_c  = (state == S_IDLE) ? aluResult_In[ADDR_W-1:0] : lat_addr;
   assign mem_wdata_c = (state == S_IDLE) ? storeData_In : lat_data;
   assign mem_rdata_c = mem[mem_addr_c];

   always_ff @(posedge clock) begin
      if (reset) begin
         state           <= S_IDLE;
         cnt             <= '0;
         lat_instr       <= '0;
         lat_addr        <= '0;
         lat_data        <= '0;
         lat_we          <= 1'b0;
         valid_Out       <= 1'b0;
         instruction_Out <= '0;
         result_Out      <= '0;
      end else begin
         state           <= state_n;
         cnt             <= cnt_n;
         lat_instr       <= lat_instr_n;
         lat_addr        <= lat_addr_n;
         lat_data        <= lat_data_n;
         lat_we          <= lat_we_n;
         valid_Out       <= valid_n;
         instruction_Out <= instr_n;
         result_Out      <= result_n;
      end
   end

   // Reset in the completion cycle must suppress a pending store.
   always_ff @(posedge clock) begin
      if (mem_we_c && !reset) begin
         mem[mem_addr_c] <= mem_wdata_c;
      end
   end

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      lat_instr_n = lat_instr;
      lat_addr_n  = lat_addr;
      lat_data_n  = lat_data;
      lat_we_n    = lat_we;
      valid_n     = 1'b0;
      instr_n     = instruction_Out;
      result_n    = result_Out;
      mem_we_c    = 1'b0;

      case (state)
         S_IDLE: begin
            if (accept_c) begin
               if (!is_mem_c) begin
                  valid_n  = 1'b1;
                  instr_n  = instruction_In;
                  result_n = (address_Control_In == 2'b01) ? inputPort_In : aluResult_In;
               end else if (!HAS_WAIT) begin
                  valid_n  = 1'b1;
                  instr_n  = instruction_In;
                  mem_we_c = writeEnable_In;
                  result_n = writeEnable_In ? storeData_In : mem_rdata_c;
               end else begin
                  state_n     = S_WAIT;
                  cnt_n       = CNT_W'(MEM_LATENCY);
                  lat_instr_n = instruction_In;
                  lat_addr_n  = aluResult_In[ADDR_W-1:0];
                  lat_data_n  = storeData_In;
                  lat_we_n    = writeEnable_In;
               end
            end
         end
         S_WAIT: begin
            if (flush) begin
               state_n = S_IDLE;
               cnt_n   = '0;
            end else if (cnt == CNT_W'(1)) begin
               state_n  = S_IDLE;
               cnt_n    = '0;
               valid_n  = 1'b1;
               instr_n  = lat_instr;
               mem_we_c = lat_we;
               result_n = lat_we ? lat_data : mem_rdata_c;
            end else begin
               cnt_n = cnt - CNT_W'(1);
            end
         end
         default: begin
            state_n = S_IDLE;
            cnt_n   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed stimulus queues expected
// write-back entries, a negedge monitor checks every valid_Out pulse.
module tb_mem_access_stage;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned ADDR_W = 8;
   localparam int unsigned LAT    = 2;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              valid_In = 1'b0;
   logic [19:0]       instruction_In = '0;
   logic [DATA_W-1:0] aluResult_In = '0;
   logic [DATA_W-1:0] storeData_In = '0;
   logic [DATA_W-1:0] inputPort_In = '0;
   logic              writeEnable_In = 1'b0;
   logic [1:0]        address_Control_In = '0;
   logic              flush = 1'b0;
   logic              busy_Out;
   logic              valid_Out;
   logic [19:0]       instruction_Out;
   logic [DATA_W-1:0] result_Out;

   typedef struct {
      logic [19:0]       ins;
      logic [DATA_W-1:0] res;
      int                cyc;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   mem_access_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_LATENCY(LAT)) dut (
      .clock              (clock),
      .reset              (reset),
      .valid_In           (valid_In),
      .instruction_In     (instruction_In),
      .aluResult_In       (aluResult_In),
      .storeData_In       (storeData_In),
      .inputPort_In       (inputPort_In),
      .writeEnable_In     (writeEnable_In),
      .address_Control_In (address_Control_In),
      .flush              (flush),
      .busy_Out           (busy_Out),
      .valid_Out          (valid_Out),
      .instruction_Out    (instruction_Out),
      .result_Out         (result_Out)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Monitor: every valid_Out pulse must match the oldest queued expectation.
   always @(negedge clock) begin
      if (valid_Out) begin
         if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_valid: cyc %0d ins 0x%0h res 0x%0h", cyc, instruction_Out, result_Out);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("wb_instr", 32'(instruction_Out), 32'(e.ins));
            chk("wb_result", 32'(result_Out), 32'(e.res));
            chk("wb_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   task automatic wait_idle();
      int guard;
      valid_In = 1'b0;
      guard = 0;
      while (busy_Out && guard < 40) begin
         @(posedge clock);
         #1;
         guard++;
      end
      if (busy_Out) chk("idle_timeout", 32'(busy_Out), 32'd0);
   endtask

   task automatic drive(input logic [19:0] ins, input logic [1:0] sel, input logic we,
                        input logic [15:0] alu, input logic [15:0] sd, input logic [15:0] inp);
      valid_In           = 1'b1;
      instruction_In     = ins;
      address_Control_In = sel;
      writeEnable_In     = we;
      aluResult_In       = alu;
      storeData_In       = sd;
      inputPort_In       = inp;
   endtask

   // One instruction: expects a write-back entry and a given number of busy cycles.
   task automatic issue(input string nm, input logic [19:0] ins, input logic [1:0] sel,
                        input logic we, input logic [15:0] alu, input logic [15:0] sd,
                        input logic [15:0] inp, input logic [15:0] exp_res, input int exp_busy);
      exp_t e;
      int   nb;
      int   guard;
      wait_idle();
      drive(ins, sel, we, alu, sd, inp);
      e.ins = ins;
      e.res = exp_res;
      e.cyc = cyc + 1 + ((sel == 2'b10) ? int'(LAT) : 0);
      q.push_back(e);
      #1;
      nb = busy_Out ? 1 : 0;
      @(posedge clock);
      #1;
      valid_In = 1'b0;
      guard = 0;
      while (busy_Out && guard < 40) begin
         nb++;
         guard++;
         @(posedge clock);
         #1;
      end
      chk({nm, "_busy"}, 32'(nb), 32'(exp_busy));
   endtask

   initial begin
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      chk("rst_valid", 32'(valid_Out), 32'd0);
      chk("rst_instr", 32'(instruction_Out), 32'd0);
      chk("rst_result", 32'(result_Out), 32'd0);
      chk("rst_busy", 32'(busy_Out), 32'd0);

      issue("alu_pass", 20'h1_0001, 2'b00, 1'b0, 16'h1234, 16'h0, 16'h0, 16'h1234, 0);
      issue("in_port", 20'hF_0002, 2'b01, 1'b0, 16'h5555, 16'h0, 16'hBEEF, 16'hBEEF, 0);
      issue("sel11", 20'h3_0003, 2'b11, 1'b0, 16'h4321, 16'h0, 16'h9999, 16'h4321, 0);
      issue("store5", 20'h8_0005, 2'b10, 1'b1, 16'h0005, 16'hA5A5, 16'h0, 16'hA5A5, 3);
      issue("load5", 20'h9_0005, 2'b10, 1'b0, 16'h0005, 16'h0, 16'h0, 16'hA5A5, 3);
      issue("store7", 20'h8_0007, 2'b10, 1'b1, 16'h0007, 16'h7777, 16'h0, 16'h7777, 3);

      // STORE killed by flush in its first wait cycle.
      wait_idle();
      drive(20'h8_0077, 2'b10, 1'b1, 16'h0007, 16'h1111, 16'h0);
      @(posedge clock);
      #1;
      valid_In = 1'b0;
      flush    = 1'b1;
      @(posedge clock);
      #1;
      flush = 1'b0;
      chk("flush_wait_busy", 32'(busy_Out), 32'd0);
      chk("flush_wait_valid", 32'(valid_Out), 32'd0);
      issue("load7", 20'h9_0007, 2'b10, 1'b0, 16'h0007, 16'h0, 16'h0, 16'h7777, 3);

      // Flush while idle drops the presented instruction.
      drive(20'h1_00FF, 2'b00, 1'b0, 16'hDEAD, 16'h0, 16'h0);
      flush = 1'b1;
      @(posedge clock);
      #1;
      flush    = 1'b0;
      valid_In = 1'b0;
      chk("flush_idle_valid", 32'(valid_Out), 32'd0);

      issue("load_wrap", 20'h9_0105, 2'b10, 1'b0, 16'h0105, 16'h0, 16'h0, 16'hA5A5, 3);
      issue("b2b_0", 20'h2_0010, 2'b00, 1'b0, 16'h0011, 16'h0, 16'h0, 16'h0011, 0);
      issue("b2b_1", 20'h2_0011, 2'b01, 1'b0, 16'h0000, 16'h0, 16'h2222, 16'h2222, 0);
      issue("b2b_2", 20'h2_0012, 2'b11, 1'b0, 16'h0033, 16'h0, 16'h0, 16'h0033, 0);

      // Reset on the completion edge of a STORE must abort it.
      issue("store9", 20'h8_0009, 2'b10, 1'b1, 16'h0009, 16'h9999, 16'h0, 16'h9999, 3);
      wait_idle();
      drive(20'h8_0099, 2'b10, 1'b1, 16'h0009, 16'h2222, 16'h0);
      @(posedge clock);
      #1;
      valid_In = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      chk("rstw_valid", 32'(valid_Out), 32'd0);
      chk("rstw_busy", 32'(busy_Out), 32'd0);
      chk("rstw_instr", 32'(instruction_Out), 32'd0);
      chk("rstw_result", 32'(result_Out), 32'd0);
      issue("load9", 20'h9_0009, 2'b10, 1'b0, 16'h0009, 16'h0, 16'h0, 16'h9999, 3);

      repeat (4) @(posedge clock);
      #1;
      chk("queue_empty", 32'(q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL global_timeout: cyc %0d", cyc);
      $fatal(1, "timeout");
   end

endmodule
